// File: rtl/gpu_pkg.sv
// Shared types and helpers for the block dispatcher and its per-core slots.
package gpu_pkg;

    typedef enum logic [1:0] {FREE, ASSIGN, RUN} slot_state_t;
    typedef enum logic [1:0] {IDLE, DISPATCH, DONE} disp_state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Width that can hold any block size from 0 up to THREADS_PER_BLOCK.
    function automatic int tpb_bits(input int threads_per_block);
        return $clog2(threads_per_block + 1);
    endfunction

endpackage

// File: rtl/dispatch_slot.sv
// One dispatch slot per core: walks FREE -> ASSIGN -> RUN and holds the block it was handed.
module dispatch_slot
    import gpu_pkg::*;
#(
    parameter int THREAD_COUNT_BITS = 8,
    parameter int TPB_BITS          = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         issue,
    input  logic [THREAD_COUNT_BITS-1:0] issue_id,
    input  logic [TPB_BITS-1:0]          issue_count,
    input  logic                         core_done,
    output logic                         core_reset,
    output logic                         core_start,
    output logic [THREAD_COUNT_BITS-1:0] block_id,
    output logic [TPB_BITS-1:0]          thread_count,
    output logic                         slot_free,
    output logic                         complete
);

    slot_state_t state, state_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= FREE;
            block_id     <= '0;
            thread_count <= '0;
        end else begin
            state <= state_next;
            if (issue && state == FREE) begin
                block_id     <= issue_id;
                thread_count <= issue_count;
            end
        end
    end

    // core_done only counts while RUN, so a level left over from the last block is ignored.
    always_comb begin
        state_next = state;
        core_reset = 1'b0;
        core_start = 1'b0;
        slot_free  = 1'b0;
        complete   = 1'b0;
        case (state)
            FREE: begin
                slot_free = 1'b1;
                if (issue) state_next = ASSIGN;
            end
            ASSIGN: begin
                core_reset = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                core_start = 1'b1;
                if (core_done) begin
                    complete   = 1'b1;
                    state_next = FREE;
                end
            end
            default: state_next = FREE;
        endcase
    end

endmodule

// File: rtl/dispatch_unit.sv
// Block dispatcher: holds the thread-count DCR, splits the kernel into blocks and feeds free cores.
module dispatch_unit
    import gpu_pkg::*;
#(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_COUNT_BITS = 8,
    localparam int TPB_BITS         = tpb_bits(THREADS_PER_BLOCK)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    output logic                                   done,
    input  logic                                   device_control_write_enable,
    input  logic [THREAD_COUNT_BITS-1:0]           device_control_data,
    output logic [NUM_CORES-1:0]                   core_reset,
    output logic [NUM_CORES-1:0]                   core_start,
    output logic [NUM_CORES*THREAD_COUNT_BITS-1:0] core_block_id,
    output logic [NUM_CORES*TPB_BITS-1:0]          core_thread_count,
    input  logic [NUM_CORES-1:0]                   core_done
);

    disp_state_t                  state, state_next;
    logic [THREAD_COUNT_BITS-1:0] dcr;
    logic                         start_q;
    logic [THREAD_COUNT_BITS:0]   next_block;
    logic [THREAD_COUNT_BITS:0]   blocks_done;
    logic [THREAD_COUNT_BITS:0]   total_blocks;
    logic [THREAD_COUNT_BITS:0]   last_block;
    logic [THREAD_COUNT_BITS:0]   complete_count;
    logic [TPB_BITS-1:0]          issue_count;
    logic [NUM_CORES-1:0]         slot_free;
    logic [NUM_CORES-1:0]         slot_complete;
    logic [NUM_CORES-1:0]         issue_vec;
    logic                         start_rise;
    logic                         launch;
    logic                         found;
    int                           last_size;

    assign start_rise   = start & ~start_q;
    assign launch       = start_rise && (state != DISPATCH);
    assign done         = (state == DONE);
    assign total_blocks = (THREAD_COUNT_BITS+1)'(ceil_div(int'(dcr), THREADS_PER_BLOCK));
    assign last_block   = total_blocks - 1'b1;
    assign last_size    = int'(dcr) - int'(last_block) * THREADS_PER_BLOCK;
    assign issue_count  = (next_block == last_block) ? TPB_BITS'(last_size)
                                                     : TPB_BITS'(THREADS_PER_BLOCK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            dcr         <= '0;
            start_q     <= 1'b0;
            next_block  <= '0;
            blocks_done <= '0;
        end else begin
            state   <= state_next;
            start_q <= start;
            if (device_control_write_enable && state != DISPATCH)
                dcr <= device_control_data;
            if (launch) begin
                next_block  <= '0;
                blocks_done <= '0;
            end else begin
                if (|issue_vec) next_block <= next_block + 1'b1;
                blocks_done <= blocks_done + complete_count;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start_rise) state_next = DISPATCH;
            DISPATCH: if (blocks_done == total_blocks) state_next = DONE;
            DONE:     if (start_rise) state_next = DISPATCH;
            default:  state_next = IDLE;
        endcase
    end

    // One issue per cycle, lowest-index free slot wins; completions may land on any number of slots.
    always_comb begin
        issue_vec      = '0;
        found          = 1'b0;
        complete_count = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            if (state == DISPATCH && next_block < total_blocks && !found && slot_free[c]) begin
                issue_vec[c] = 1'b1;
                found        = 1'b1;
            end
            complete_count = complete_count + {{THREAD_COUNT_BITS{1'b0}}, slot_complete[c]};
        end
    end

    for (genvar c = 0; c < NUM_CORES; c++) begin : g_slot
        dispatch_slot #(
            .THREAD_COUNT_BITS(THREAD_COUNT_BITS),
            .TPB_BITS         (TPB_BITS)
        ) u_slot (
            .clk         (clk),
            .reset       (reset),
            .issue       (issue_vec[c]),
            .issue_id    (next_block[THREAD_COUNT_BITS-1:0]),
            .issue_count (issue_count),
            .core_done   (core_done[c]),
            .core_reset  (core_reset[c]),
            .core_start  (core_start[c]),
            .block_id    (core_block_id[c*THREAD_COUNT_BITS +: THREAD_COUNT_BITS]),
            .thread_count(core_thread_count[c*TPB_BITS +: TPB_BITS]),
            .slot_free   (slot_free[c]),
            .complete    (slot_complete[c])
        );
    end

endmodule
